// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared defaults, state encoding and compare codes for the root verifier
package sqrt_pkg;

    localparam int RAD_W_DEF  = 20;
    localparam int ROOT_W_DEF = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

    // one-hot {lt, eq, gt}
    localparam logic [2:0] CMP_LT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_GT = 3'b001;

endpackage

// File: rtl/sqrt_shift_add_sq.sv
// rtl/sqrt_shift_add_sq.sv - sequential shift-add squarer datapath, one multiplier bit per cycle
// Ports: clk, rst (sync, active-high); load captures root and clears acc/count;
// step performs one LSB-first iteration; mcand holds the captured root;
// acc is the running square; last flags the final iteration.
// Macro SQRT_VERIFY_EARLY_EXIT_EN: last asserts once the shifted multiplier is zero.
module sqrt_shift_add_sq
    import sqrt_pkg::*;
#(
    parameter int ROOT_W = ROOT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [ROOT_W-1:0]     root,
    output logic [ROOT_W-1:0]     mcand,
    output logic [2*ROOT_W-1:0]   acc,
    output logic                  last
);

    localparam int SQ_W  = 2 * ROOT_W;
    localparam int CNT_W = $clog2(ROOT_W) + 1;

    logic [ROOT_W-1:0] mplier;
    logic [CNT_W-1:0]  count;
    logic [SQ_W-1:0]   partial;

    // widen before shifting so the top partial product is never truncated
    assign partial = {{ROOT_W{1'b0}}, mcand} << count;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (load) begin
            mcand  <= root;
            mplier <= root;
            acc    <= '0;
            count  <= '0;
        end else if (step) begin
            if (mplier[0]) begin
                acc <= acc + partial;
            end
            mplier <= mplier >> 1;
            count  <= count + CNT_W'(1);
        end
    end

`ifdef SQRT_VERIFY_EARLY_EXIT_EN
    // no set bits remain above bit 0, so this iteration is the final one
    assign last = (mplier[ROOT_W-1:1] == '0);
`else
    assign last = (count == CNT_W'(ROOT_W - 1));
`endif

endmodule

// File: rtl/sqrt_root_verify.sv
// rtl/sqrt_root_verify.sv - squares a candidate root and checks it is the floor square root of the radicand
// Ports: clk, rst (sync, active-high); start/root/radicand request a check (sampled in IDLE);
// busy high outside IDLE; done one-cycle pulse; square = root*root;
// sq_lt/sq_eq/sq_gt one-hot compare of square vs radicand; is_floor = square <= radicand < (root+1)^2.
// Results hold after done until the next accepted start.
// Macro SQRT_VERIFY_EARLY_EXIT_EN: multiply ends once remaining multiplier bits are zero.
module sqrt_root_verify
    import sqrt_pkg::*;
#(
    parameter int RAD_W  = RAD_W_DEF,
    parameter int ROOT_W = ROOT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ROOT_W-1:0]     root,
    input  logic [RAD_W-1:0]      radicand,
    output logic                  busy,
    output logic                  done,
    output logic [2*ROOT_W-1:0]   square,
    output logic                  sq_lt,
    output logic                  sq_eq,
    output logic                  sq_gt,
    output logic                  is_floor
);

    localparam int SQ_W  = 2 * ROOT_W;
    localparam int EXT_W = SQ_W + 1;

    state_t            state;
    state_t            state_nxt;
    logic              load;
    logic              step;
    logic              mul_last;
    logic [ROOT_W-1:0] mcand;
    logic [SQ_W-1:0]   acc;
    logic [RAD_W-1:0]  rad_q;

    logic [EXT_W-1:0]  acc_x;
    logic [EXT_W-1:0]  rad_x;
    logic [EXT_W-1:0]  next_x;
    logic [2:0]        cmp_code;
    logic              floor_ok;

    sqrt_shift_add_sq #(
        .ROOT_W (ROOT_W)
    ) u_sq (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .step  (step),
        .root  (root),
        .mcand (mcand),
        .acc   (acc),
        .last  (mul_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)    state_nxt = MUL;
            MUL:     if (mul_last) state_nxt = CMP;
            CMP:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
        load = (state == IDLE) && start;
        step = (state == MUL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rad_q <= '0;
        end else if (load) begin
            rad_q <= radicand;
        end
    end

    // one spare bit so (root+1)^2 = acc + 2*root + 1 cannot wrap
    always_comb begin
        acc_x  = EXT_W'(acc);
        rad_x  = EXT_W'(rad_q);
        next_x = acc_x + (EXT_W'(mcand) << 1) + EXT_W'(1);
        if (acc_x < rad_x) begin
            cmp_code = CMP_LT;
        end else if (acc_x == rad_x) begin
            cmp_code = CMP_EQ;
        end else begin
            cmp_code = CMP_GT;
        end
        floor_ok = (acc_x <= rad_x) && (next_x > rad_x);
    end

    always_ff @(posedge clk) begin
        if (rst || load) begin
            square   <= '0;
            sq_lt    <= 1'b0;
            sq_eq    <= 1'b0;
            sq_gt    <= 1'b0;
            is_floor <= 1'b0;
        end else if (state == CMP) begin
            square                <= acc;
            {sq_lt, sq_eq, sq_gt} <= cmp_code;
            is_floor              <= floor_ok;
        end
    end

endmodule

// File: tb/tb_sqrt_root_verify.sv
// tb/tb_sqrt_root_verify.sv - self-checking bench for sqrt_root_verify
module tb_sqrt_root_verify;

    localparam int RAD_W  = 20;
    localparam int ROOT_W = 11;
    localparam int SQ_W   = 2 * ROOT_W;

`ifdef SQRT_VERIFY_EARLY_EXIT_EN
    localparam int POKE_CYC = 2;
`else
    localparam int POKE_CYC = 5;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ROOT_W-1:0] root = '0;
    logic [RAD_W-1:0]  radicand = '0;
    logic              busy;
    logic              done;
    logic [SQ_W-1:0]   square;
    logic              sq_lt;
    logic              sq_eq;
    logic              sq_gt;
    logic              is_floor;

    int checks = 0;
    int errors = 0;
    int dones_seen = 0;

    always #5 clk = ~clk;

    sqrt_root_verify dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .root     (root),
        .radicand (radicand),
        .busy     (busy),
        .done     (done),
        .square   (square),
        .sq_lt    (sq_lt),
        .sq_eq    (sq_eq),
        .sq_gt    (sq_gt),
        .is_floor (is_floor)
    );

    typedef struct packed {
        logic [SQ_W-1:0] sq;
        logic            lt;
        logic            eq;
        logic            gt;
        logic            fl;
    } res_t;

    function automatic int bitlen(input int v);
        int b = 0;
        int x = v;
        while (x > 0) begin
            b++;
            x = x >> 1;
        end
        return b;
    endfunction

    function automatic int model_latency(input int r);
`ifdef SQRT_VERIFY_EARLY_EXIT_EN
        return ((bitlen(r) > 1) ? bitlen(r) : 1) + 2;
`else
        return ROOT_W + 2;
`endif
    endfunction

    function automatic res_t model_result(input int r, input int rad);
        res_t   res;
        longint s  = longint'(r) * longint'(r);
        longint nx = longint'(r + 1) * longint'(r + 1);
        longint rd = longint'(rad);
        res.sq = s[SQ_W-1:0];
        res.lt = (s < rd);
        res.eq = (s == rd);
        res.gt = (s > rd);
        res.fl = (s <= rd) && (nx > rd);
        return res;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: interval n is the time after the n-th rising edge.
    int   n = 0;
    int   busy_end = -1;
    bit   chk_en = 1'b0;
    res_t m_res = '0;
    res_t p_res = '0;

    always @(posedge clk) begin
        n <= n + 1;
        if (rst) begin
            busy_end <= -1;
            m_res    <= '0;
            chk_en   <= 1'b1;
        end else if (chk_en && busy_end < n && start) begin
            busy_end <= n + model_latency(int'(root));
            p_res    <= model_result(int'(root), int'(radicand));
            m_res    <= '0;
        end else if (busy_end == n + 1) begin
            m_res <= p_res;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",     busy,     (busy_end >= n));
            chk("done",     done,     (busy_end == n));
            chk("square",   square,   m_res.sq);
            chk("sq_lt",    sq_lt,    m_res.lt);
            chk("sq_eq",    sq_eq,    m_res.eq);
            chk("sq_gt",    sq_gt,    m_res.gt);
            chk("is_floor", is_floor, m_res.fl);
            if (done) dones_seen++;
        end
    end

    task automatic run_directed(input int r, input int rad, input longint e_sq,
                                input bit e_lt, input bit e_eq, input bit e_gt,
                                input bit e_fl, input int e_lat, input int poke);
        int k = 0;
        bit seen = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        root     = ROOT_W'(r);
        radicand = RAD_W'(rad);
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            start = (poke != 0 && k == poke);
            if (poke != 0 && k == poke) begin
                root     = ROOT_W'(5);
                radicand = RAD_W'(25);
            end else begin
                root     = ROOT_W'($urandom);
                radicand = RAD_W'($urandom);
            end
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        chk("dir_done_seen", seen, 1);
        if (seen) begin
            chk("dir_latency",  k,        e_lat);
            chk("dir_square",   square,   e_sq);
            chk("dir_sq_lt",    sq_lt,    e_lt);
            chk("dir_sq_eq",    sq_eq,    e_eq);
            chk("dir_sq_gt",    sq_gt,    e_gt);
            chk("dir_is_floor", is_floor, e_fl);
        end
        @(negedge clk);
    endtask

    initial begin
        int r;
        int rad;
        int k;
        bit seen;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_busy",   busy,   0);
        chk("reset_done",   done,   0);
        chk("reset_square", square, 0);
        chk("reset_flags",  {sq_lt, sq_eq, sq_gt, is_floor}, 0);
        rst = 1'b0;
        @(negedge clk);

`ifdef SQRT_VERIFY_EARLY_EXIT_EN
        run_directed(3,    9,       9,       0, 1, 0, 1, 4,  POKE_CYC);
        run_directed(31,   1000,    961,     1, 0, 0, 1, 7,  0);
        run_directed(32,   1000,    1024,    0, 0, 1, 0, 8,  0);
        run_directed(1023, 1048575, 1046529, 1, 0, 0, 1, 12, 0);
        run_directed(2047, 0,       4190209, 0, 0, 1, 0, 13, 0);
        run_directed(0,    0,       0,       0, 1, 0, 1, 3,  0);
        run_directed(1024, 1048575, 1048576, 0, 0, 1, 0, 13, 0);
`else
        run_directed(3,    9,       9,       0, 1, 0, 1, 13, POKE_CYC);
        run_directed(31,   1000,    961,     1, 0, 0, 1, 13, 0);
        run_directed(32,   1000,    1024,    0, 0, 1, 0, 13, 0);
        run_directed(1023, 1048575, 1046529, 1, 0, 0, 1, 13, 0);
        run_directed(2047, 0,       4190209, 0, 0, 1, 0, 13, 0);
        run_directed(0,    0,       0,       0, 1, 0, 1, 13, 0);
        run_directed(1024, 1048575, 1048576, 0, 0, 1, 0, 13, 0);
`endif

        // reset in the middle of a computation
        @(negedge clk);
        start    = 1'b1;
        root     = ROOT_W'(1024);
        radicand = RAD_W'(1048575);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 6) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy",   busy,   0);
        chk("midrst_square", square, 0);
        chk("midrst_flags",  {sq_lt, sq_eq, sq_gt, is_floor}, 0);
        seen = 1'b0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("midrst_no_done", seen, 0);
        run_directed(32, 1000, 1024, 0, 0, 1, 0, model_latency(32), 0);

        // randomized traffic with stray starts and occasional resets
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) begin
                r   = int'($urandom_range(0, 2047));
                rad = int'($urandom_range(0, 1048575));
            end else begin
                r = int'($urandom_range(0, 1023));
                case ($urandom_range(0, 4))
                    0:       rad = r * r - 1;
                    1:       rad = r * r;
                    2:       rad = r * r + 1;
                    3:       rad = r * r + 2 * r;
                    default: rad = r * r + 2 * r + 1;
                endcase
                if (rad < 0) rad = 0;
                if (rad > 1048575) rad = 1048575;
            end
            root     = ROOT_W'(r);
            radicand = RAD_W'(rad);
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("random_activity", (dones_seen > 100), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
